// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_unit
// Brief    : EX-stage branch/jump resolution with a bimodal 2-bit BHT that
//            gives IF a taken prediction. A mispredict holds flush high for
//            FLUSH_CYCLES cycles.
// Options  : BRANCH_STATS_EN - when defined, adds saturating 16-bit branch
//            and mispredict counters. When undefined, both outputs read 0.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 16,
    parameter int IDX_LSB      = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetchPc,
    output logic            predTaken,
    input  logic            exValid,
    input  logic [XLEN-1:0] exPc,
    input  logic            exPredTaken,
    input  logic [4:0]      brOp,
    input  logic [XLEN-1:0] ruRs1,
    input  logic [XLEN-1:0] ruRs2,
    output logic            nextPcSrc,
    output logic            mispredict,
    output logic            flush,
    output logic [15:0]     brCount,
    output logic [15:0]     mispCount
);

    localparam int         c_IDX_W      = $clog2(BHT_ENTRIES);
    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [1:0] c_CTR_RESET  = 2'b01;
    localparam logic [1:0] c_CTR_MAX    = 2'b11;
    localparam logic [1:0] c_CTR_MIN    = 2'b00;
    localparam logic [1:0] c_CLS_NONE   = 2'b00;
    localparam logic [1:0] c_CLS_COND   = 2'b01;

    logic                   w_eq;
    logic                   w_lt_s;
    logic                   w_lt_u;
    logic                   w_cond_taken;
    logic                   w_taken;
    logic                   w_qual;
    logic                   w_train;
    logic [c_IDX_W-1:0]     w_rd_idx;
    logic [c_IDX_W-1:0]     w_wr_idx;
    logic [BHT_ENTRIES-1:0] w_bht_msb;
    logic [3:0]             r_fcnt_q;
    logic [3:0]             w_fcnt_d;
    logic                   w_unused_pc;

    // Only the index field of each PC reaches the table.
    assign w_unused_pc = ^{fetchPc, exPc};

    // Resolve the branch condition from brOp and the register operands.
    always_comb begin
        w_eq         = (ruRs1 == ruRs2);
        w_lt_s       = ($signed(ruRs1) < $signed(ruRs2));
        w_lt_u       = (ruRs1 < ruRs2);
        w_cond_taken = 1'b0;
        case (brOp[2:0])
            3'b000:  w_cond_taken = w_eq;
            3'b001:  w_cond_taken = ~w_eq;
            3'b100:  w_cond_taken = w_lt_s;
            3'b101:  w_cond_taken = ~w_lt_s;
            3'b110:  w_cond_taken = w_lt_u;
            3'b111:  w_cond_taken = ~w_lt_u;
            default: w_cond_taken = 1'b0;
        endcase
        w_taken = 1'b0;
        if (brOp[4]) begin
            w_taken = 1'b1;
        end else if (brOp[3]) begin
            w_taken = w_cond_taken;
        end
    end

    // A wrong-path instruction during flush, or anything under reset, is ignored.
    assign w_qual     = exValid & ~flush & ~rst;
    assign nextPcSrc  = w_qual & w_taken;
    assign mispredict = w_qual & (w_taken != exPredTaken);
    assign w_train    = w_qual & (brOp[4:3] == c_CLS_COND);

    assign w_rd_idx   = fetchPc[IDX_LSB +: c_IDX_W];
    assign w_wr_idx   = exPc[IDX_LSB +: c_IDX_W];
    assign predTaken  = w_bht_msb[w_rd_idx];

    for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_bht
        logic [1:0] r_ctr_q;
        logic [1:0] w_ctr_d;
        logic       w_hit;

        assign w_hit        = w_train & (w_wr_idx == c_IDX_W'(g));
        assign w_bht_msb[g] = r_ctr_q[1];

        // Saturating up/down update of this counter when EX trains it.
        always_comb begin
            w_ctr_d = r_ctr_q;
            if (w_hit) begin
                if (w_taken) begin
                    if (r_ctr_q != c_CTR_MAX) begin
                        w_ctr_d = r_ctr_q + 2'd1;
                    end
                end else begin
                    if (r_ctr_q != c_CTR_MIN) begin
                        w_ctr_d = r_ctr_q - 2'd1;
                    end
                end
            end
        end

        // Counter register; reset to weakly not-taken.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ctr_q <= c_CTR_RESET;
            end else begin
                r_ctr_q <= w_ctr_d;
            end
        end
    end

    // Flush countdown: load on mispredict, otherwise count down to zero.
    always_comb begin
        w_fcnt_d = r_fcnt_q;
        if (mispredict) begin
            w_fcnt_d = c_FLUSH_LOAD;
        end else if (r_fcnt_q != 4'd0) begin
            w_fcnt_d = r_fcnt_q - 4'd1;
        end
    end

    // Flush counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt_q <= 4'd0;
        end else begin
            r_fcnt_q <= w_fcnt_d;
        end
    end

    assign flush = (r_fcnt_q != 4'd0);

`ifdef BRANCH_STATS_EN
    logic [15:0] r_br_cnt_q;
    logic [15:0] w_br_cnt_d;
    logic [15:0] r_misp_cnt_q;
    logic [15:0] w_misp_cnt_d;

    // Saturating statistics: qualified branches/jumps and mispredicts.
    always_comb begin
        w_br_cnt_d   = r_br_cnt_q;
        w_misp_cnt_d = r_misp_cnt_q;
        if (w_qual && (brOp[4:3] != c_CLS_NONE) && (r_br_cnt_q != 16'hFFFF)) begin
            w_br_cnt_d = r_br_cnt_q + 16'd1;
        end
        if (mispredict && (r_misp_cnt_q != 16'hFFFF)) begin
            w_misp_cnt_d = r_misp_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cnt_q   <= 16'd0;
            r_misp_cnt_q <= 16'd0;
        end else begin
            r_br_cnt_q   <= w_br_cnt_d;
            r_misp_cnt_q <= w_misp_cnt_d;
        end
    end

    assign brCount   = r_br_cnt_q;
    assign mispCount = r_misp_cnt_q;
`else
    assign brCount   = 16'd0;
    assign mispCount = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the combinational branch unit for the pipelined RV32 core. It resolves branch and jump conditions in EX and produces `nextPcSrc` from the same `brOp` encoding. It adds a direct-mapped bimodal branch history table (BHT) of 2-bit saturating counters that gives IF a taken prediction. When EX disagrees with the prediction carried down the pipe, it flags a mispredict and drives a multi-cycle `flush` for the younger stages.

## Interface
Parameters:
- `XLEN`, 32, operand and PC width.
- `BHT_ENTRIES`, 16, number of counters; power of two, minimum 2.
- `IDX_LSB`, 2, lowest PC bit used for the BHT index.
- `FLUSH_CYCLES`, 2, cycles `flush` stays high after a mispredict; range 1–15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `fetchPc`  input  XLEN  IF-stage PC used for BHT lookup.
- `predTaken`  output  1  prediction for `fetchPc`: MSB of the indexed counter.
- `exValid`  input  1  EX holds a valid instruction.
- `exPc`  input  XLEN  PC of the EX instruction.
- `exPredTaken`  input  1  prediction originally issued for the EX instruction.
- `brOp`  input  5  branch operation (encoding below).
- `ruRs1`, `ruRs2`  input  XLEN  register operands.
- `nextPcSrc`  output  1  1 = take the branch or jump target.
- `mispredict`  output  1  `nextPcSrc` differs from `exPredTaken` on a qualified instruction.
- `flush`  output  1  squash IF/ID; registered.
- `brCount`, `mispCount`  output  16  statistics counters (see Configuration).

## Operation
`brOp` encoding:
- `00xxx`: no branch; taken = 0.
- `1xxxx`: unconditional jump; taken = 1.
- `01xxx`: conditional branch, selected by the low 3 bits:
  - 000 BEQ, 001 BNE
  - 100 BLT, 101 BGE (signed)
  - 110 BLTU, 111 BGEU (unsigned)
  - 010 and 011 are reserved; taken = 0.

Qualification and outputs:
- `q = exValid & ~flush & ~rst`.
- `nextPcSrc = q & taken`.
- `mispredict = q & (taken != exPredTaken)`.

BHT:
- `BHT_ENTRIES` 2-bit counters.
- Index = `pc[IDX_LSB +: log2(BHT_ENTRIES)]`, using `fetchPc` for reads and `exPc` for updates.
- Trained only when `q` is high and `brOp[4:3]==01`:
  - taken: increment, saturating at 11.
  - not taken: decrement, saturating at 00.
- Jumps and non-branches never modify the table.

Flush counter (`fcnt`, 4 bits):
- On a cycle with `mispredict`, `fcnt` loads `FLUSH_CYCLES`.
- Otherwise, if nonzero, `fcnt` decrements.
- `flush = (fcnt != 0)`.
- While `flush` is high, the EX instruction is wrong-path: no training, no `mispredict`, `nextPcSrc`=0.

Reset (`rst` high at a rising edge, including mid-flush):
- Every counter becomes 01 (weakly not-taken), so `predTaken`=0.
- `fcnt`=0, so `flush`=0.
- `brCount`=`mispCount`=0.
- `nextPcSrc` and `mispredict` are forced to 0 while `rst` is high.

## Timing
- `nextPcSrc` and `mispredict` are combinational from the EX inputs in the same cycle (zero latency).
- `predTaken` is a combinational read of the registered table.
- BHT writes commit at the edge ending cycle t and are visible to lookups from t+1.
  - A same-cycle read of the entry being updated returns the old value.
- If a mispredict occurs in cycle t, `flush` is high in cycles t+1 … t+`FLUSH_CYCLES` and low at t+`FLUSH_CYCLES`+1.
- A mispredict cannot occur while `flush` is high, so there is no reload during a flush. Back-to-back mispredicts are separated by at least `FLUSH_CYCLES` cycles.
- Signed compares use `$signed` at the full `XLEN`; unsigned compares use the raw vectors. There is no width extension.

## Configuration
`BRANCH_STATS_EN`:
- Defined:
  - `brCount` increments on every qualified instruction with `brOp[4:3]!=00`.
  - `mispCount` increments on every `mispredict`.
  - Both are 16-bit and saturate at 0xFFFF.
  - Both are cleared by `rst`.
- Undefined: no counter registers exist, and both outputs are tied to 0.

## Test plan
- Reset, then `fetchPc`=any → `predTaken`=0; `flush`=0; counters 0.
- `brOp`=01000 (BEQ), rs1=7, rs2=3, `exPredTaken`=0, `exValid`=1 → `nextPcSrc`=0, `mispredict`=0, `flush` stays 0.
- `brOp`=01101 (BGE), rs1=7, rs2=3, `exPredTaken`=0 → `nextPcSrc`=1, `mispredict`=1. `flush` is 1 for exactly 2 cycles. EX inputs during those cycles produce no training and no `mispredict`.
- Signed vs unsigned compares:
  - `brOp`=01100 (BLT), rs1=0xFFFFFFFF, rs2=1 → taken.
  - `brOp`=01110 (BLTU), same operands → not taken.
- Saturation at `exPc`=0x40: three taken BEQ updates → counter 11. `fetchPc`=0x40 then gives `predTaken`=1. Two not-taken updates give `predTaken`=0. Aliasing `fetchPc`=0x80 (16 entries) returns the same counter.
- Assert `rst` in the cycle after a mispredict → `flush` is 0 from the next cycle, and `predTaken`=0 for every index.
